operand_fetch_stage: RTL and testbench
======================================

Name: operand_fetch_stage

Overview:
- Parametrised successor of the data-select stage: reads NUM_RS source registers, resolves RAW hazards against NUM_FW forwarding sources, and builds op1/op2.
- Registers the result into a one-entry valid/ready pipeline slot.
- Sits between decode and execute.
- Adds a registered output, backpressure, flush, an x0-forced-zero rule and a saturating hazard-stall counter.

Parameters:
XLEN, 32, register/data width
NUM_RS, 2, source register read ports (2..3; port 2 exists only when NUM_RS=3)
NUM_FW, 4, forwarding sources; index 0 = youngest/highest priority
IID_W, 64, instruction-id width

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
flush  in  1  kill the held slot and any accepted input this cycle
in_valid  in  1  decoded instruction present
in_ready  out  1  stage accepts the input this cycle
in_pc  in  XLEN  instruction PC
in_iid  in  IID_W  instruction id
in_rs_addr  in  NUM_RS*5  source register numbers, port k at [5k+4:5k]
in_op1_sel  in  2  0=zero 1=RS1 2=PC 3=IMZ
in_op2_sel  in  3  0=zero 1=RS2 2=IMI 3=IMS 4=IMJ 5=IMU; 6,7=zero
in_imm_i/in_imm_s/in_imm_j/in_imm_u/in_imm_z  in  XLEN each  immediates
rf_raddr  out  NUM_RS*5  register file read addresses (= in_rs_addr)
rf_rdata  in  NUM_RS*XLEN  combinational register file data
fw_valid  in  NUM_FW  source k holds a pending write
fw_addr  in  NUM_FW*5  destination register
fw_fwdable  in  NUM_FW  fw_wdata is final
fw_wdata  in  NUM_FW*XLEN  forwarded value
out_valid  out  1  slot holds an instruction
out_ready  in  1  execute consumes the slot
out_pc  out  XLEN  registered PC
out_iid  out  IID_W  registered id
out_op1  out  XLEN  registered operand 1
out_op2  out  XLEN  registered operand 2
out_rs_data  out  NUM_RS*XLEN  registered resolved source data
hazard  out  1  combinational: input blocked by a non-forwardable match
stall_cycles  out  32  saturating count of cycles with hazard=1

Behaviour:
- Reset: out_valid=0; out_pc, out_iid, out_op1, out_op2, out_rs_data = 0; stall_cycles=0.
- Per port k, match_k_j = fw_valid[j] & fw_addr[j]==rs_k & rs_k!=0.
- The lowest j with a match wins. Resolved data: winner's fw_wdata, else rf_rdata_k; rs_k==0 forces 0 regardless of rf_rdata or forwarding.
- A port is blocked if its winning source has fw_fwdable=0; lower-priority matches are ignored.
- hazard = in_valid & any port blocked & !flush.
- in_ready = !flush & !hazard & (!out_valid | out_ready).
- Accept = in_valid & in_ready: on the next edge the slot loads the input with out_valid=1. Latency is 1 cycle.
- out_valid & out_ready & !accept: the slot empties (out_valid=0).
- Simultaneous consume and accept: the slot is replaced, giving a full-throughput bubble-free stream.
- Slot held (out_valid=1, out_ready=0): all out_* stay stable; in_ready=0.
- Hazard is re-evaluated every cycle on live fw_* inputs. When the blocking source becomes fwdable or retires, the input is accepted that cycle with the current value.
- flush: out_valid<=0 next edge; no accept that cycle. The data registers may keep stale values.
- stall_cycles increments when hazard=1 and holds at 0xFFFF_FFFF. Only reset clears it.
- Asynchronous reset asserted mid-stream clears the slot immediately. The in-flight instruction is dropped.
- Operand selects: op1 uses resolved rs0 when sel=1; op2 uses resolved rs1 when sel=1.

Test Plan:
- Reset, then in_valid with rs=(1,2), rf=(0x11,0x22), sel=(1,1), no fw -> next cycle out_valid=1, out_op1=0x11, out_op2=0x22, latency 1.
- rs0=5; fw0 and fw2 both addr 5, fwdable, wdata 0xA/0xC -> out_op1=0xA.
- rs1=7; fw1 addr 7 fwdable=0 for 3 cycles then 1 with 0x77 -> in_ready=0 for 3 cycles, stall_cycles=3, then out_op2=0x77.
- rs0=0, rf_rdata0=0xDEAD, fw0 addr 0 valid -> out_op1=0 and no hazard. Separately op1_sel=2, pc=0x8000_0004 -> out_op1=0x8000_0004.
- out_ready=0 for 4 cycles with a new input waiting -> outputs stable, in_ready=0. Then out_ready=1 -> consume and accept on the same edge, out_valid stays 1 with the new iid.
- flush with out_valid=1 and in_valid=1 -> next cycle out_valid=0, nothing accepted. Reset asserted mid-hold -> out_valid=0 immediately and stall_cycles=0.

Source files
------------

// File: rtl/operand_fetch_stage.sv
// Operand fetch stage: reads source registers, resolves RAW hazards against
// prioritised forwarding sources, builds op1/op2 and registers them into a one-entry slot.
module operand_fetch_stage #(
  parameter int XLEN   = 32,
  parameter int NUM_RS = 2,
  parameter int NUM_FW = 4,
  parameter int IID_W  = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [XLEN-1:0]          in_pc,
  input  logic [IID_W-1:0]         in_iid,
  input  logic [NUM_RS*5-1:0]      in_rs_addr,
  input  logic [1:0]               in_op1_sel,
  input  logic [2:0]               in_op2_sel,
  input  logic [XLEN-1:0]          in_imm_i,
  input  logic [XLEN-1:0]          in_imm_s,
  input  logic [XLEN-1:0]          in_imm_j,
  input  logic [XLEN-1:0]          in_imm_u,
  input  logic [XLEN-1:0]          in_imm_z,
  output logic [NUM_RS*5-1:0]      rf_raddr,
  input  logic [NUM_RS*XLEN-1:0]   rf_rdata,
  input  logic [NUM_FW-1:0]        fw_valid,
  input  logic [NUM_FW*5-1:0]      fw_addr,
  input  logic [NUM_FW-1:0]        fw_fwdable,
  input  logic [NUM_FW*XLEN-1:0]   fw_wdata,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_pc,
  output logic [IID_W-1:0]         out_iid,
  output logic [XLEN-1:0]          out_op1,
  output logic [XLEN-1:0]          out_op2,
  output logic [NUM_RS*XLEN-1:0]   out_rs_data,
  output logic                     hazard,
  output logic [31:0]              stall_cycles
);

  logic [NUM_RS*XLEN-1:0] rs_flat;
  logic [NUM_RS-1:0]      port_blocked;
  logic [XLEN-1:0]        op1, op2;
  logic                   accept;

  logic                   valid_q, valid_d;
  logic [XLEN-1:0]        pc_q, pc_d;
  logic [IID_W-1:0]       iid_q, iid_d;
  logic [XLEN-1:0]        op1_q, op1_d;
  logic [XLEN-1:0]        op2_q, op2_d;
  logic [NUM_RS*XLEN-1:0] rs_data_q, rs_data_d;
  logic [31:0]            stall_q, stall_d;

  assign rf_raddr = in_rs_addr;

  // Scan sources youngest-first; only the first match counts, even if it is not yet forwardable
  always_comb begin
    logic hit;
    rs_flat      = '0;
    port_blocked = '0;
    for (int k = 0; k < NUM_RS; k++) begin
      hit = 1'b0;
      rs_flat[k*XLEN +: XLEN] = rf_rdata[k*XLEN +: XLEN];
      for (int j = 0; j < NUM_FW; j++) begin
        if (!hit && fw_valid[j] && (fw_addr[j*5 +: 5] == in_rs_addr[k*5 +: 5]) &&
            (in_rs_addr[k*5 +: 5] != 5'd0)) begin
          hit                     = 1'b1;
          port_blocked[k]         = !fw_fwdable[j];
          rs_flat[k*XLEN +: XLEN] = fw_wdata[j*XLEN +: XLEN];
        end
      end
      if (in_rs_addr[k*5 +: 5] == 5'd0) begin
        rs_flat[k*XLEN +: XLEN] = '0;
      end
    end
  end

  always_comb begin
    op1 = '0;
    unique case (in_op1_sel)
      2'd1:    op1 = rs_flat[XLEN-1:0];
      2'd2:    op1 = in_pc;
      2'd3:    op1 = in_imm_z;
      default: op1 = '0;
    endcase
  end

  always_comb begin
    op2 = '0;
    case (in_op2_sel)
      3'd1:    op2 = rs_flat[2*XLEN-1:XLEN];
      3'd2:    op2 = in_imm_i;
      3'd3:    op2 = in_imm_s;
      3'd4:    op2 = in_imm_j;
      3'd5:    op2 = in_imm_u;
      default: op2 = '0;
    endcase
  end

  assign hazard   = in_valid & (|port_blocked) & !flush;
  assign in_ready = !flush & !hazard & (!valid_q | out_ready);
  assign accept   = in_valid & in_ready;

  // Data registers only move on accept, so a held slot stays bit-stable
  always_comb begin
    valid_d   = valid_q;
    pc_d      = pc_q;
    iid_d     = iid_q;
    op1_d     = op1_q;
    op2_d     = op2_q;
    rs_data_d = rs_data_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d   = 1'b1;
      pc_d      = in_pc;
      iid_d     = in_iid;
      op1_d     = op1;
      op2_d     = op2;
      rs_data_d = rs_flat;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (hazard && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q   <= 1'b0;
      pc_q      <= '0;
      iid_q     <= '0;
      op1_q     <= '0;
      op2_q     <= '0;
      rs_data_q <= '0;
      stall_q   <= '0;
    end else begin
      valid_q   <= valid_d;
      pc_q      <= pc_d;
      iid_q     <= iid_d;
      op1_q     <= op1_d;
      op2_q     <= op2_d;
      rs_data_q <= rs_data_d;
      stall_q   <= stall_d;
    end
  end

  assign out_valid    = valid_q;
  assign out_pc       = pc_q;
  assign out_iid      = iid_q;
  assign out_op1      = op1_q;
  assign out_op2      = op2_q;
  assign out_rs_data  = rs_data_q;
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed testbench for operand_fetch_stage: forwarding priority, hazard stalls,
// backpressure, flush, x0 rule and asynchronous reset, all with hand-computed values.
module tb_operand_fetch_stage;

  localparam int XLEN   = 32;
  localparam int NUM_RS = 2;
  localparam int NUM_FW = 4;
  localparam int IID_W  = 64;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   flush;
  logic                   in_valid;
  logic                   in_ready;
  logic [XLEN-1:0]        in_pc;
  logic [IID_W-1:0]       in_iid;
  logic [NUM_RS*5-1:0]    in_rs_addr;
  logic [1:0]             in_op1_sel;
  logic [2:0]             in_op2_sel;
  logic [XLEN-1:0]        in_imm_i, in_imm_s, in_imm_j, in_imm_u, in_imm_z;
  logic [NUM_RS*5-1:0]    rf_raddr;
  logic [NUM_RS*XLEN-1:0] rf_rdata;
  logic [NUM_FW-1:0]      fw_valid;
  logic [NUM_FW*5-1:0]    fw_addr;
  logic [NUM_FW-1:0]      fw_fwdable;
  logic [NUM_FW*XLEN-1:0] fw_wdata;
  logic                   out_valid;
  logic                   out_ready;
  logic [XLEN-1:0]        out_pc;
  logic [IID_W-1:0]       out_iid;
  logic [XLEN-1:0]        out_op1;
  logic [XLEN-1:0]        out_op2;
  logic [NUM_RS*XLEN-1:0] out_rs_data;
  logic                   hazard;
  logic [31:0]            stall_cycles;

  int checks = 0;
  int errors = 0;

  operand_fetch_stage #(
    .XLEN(XLEN), .NUM_RS(NUM_RS), .NUM_FW(NUM_FW), .IID_W(IID_W)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_iid(in_iid),
    .in_rs_addr(in_rs_addr), .in_op1_sel(in_op1_sel), .in_op2_sel(in_op2_sel),
    .in_imm_i(in_imm_i), .in_imm_s(in_imm_s), .in_imm_j(in_imm_j),
    .in_imm_u(in_imm_u), .in_imm_z(in_imm_z),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .fw_valid(fw_valid), .fw_addr(fw_addr), .fw_fwdable(fw_fwdable), .fw_wdata(fw_wdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_iid(out_iid),
    .out_op1(out_op1), .out_op2(out_op2), .out_rs_data(out_rs_data),
    .hazard(hazard), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [4:0] rs0, input logic [4:0] rs1,
                               input logic [1:0] sel1, input logic [2:0] sel2,
                               input logic [63:0] iid);
    in_valid   = valid;
    in_rs_addr = {rs1, rs0};
    in_op1_sel = sel1;
    in_op2_sel = sel2;
    in_iid     = iid;
  endtask

  task automatic setFw(input int j, input logic v, input logic [4:0] a, input logic f,
                       input logic [31:0] d);
    fw_valid[j]           = v;
    fw_addr[5*j +: 5]     = a;
    fw_fwdable[j]         = f;
    fw_wdata[32*j +: 32]  = d;
  endtask

  task automatic nextEdge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; out_ready = 1'b1;
    in_pc = '0; in_imm_i = '0; in_imm_s = '0; in_imm_j = '0; in_imm_u = '0; in_imm_z = '0;
    rf_rdata = '0; fw_valid = '0; fw_addr = '0; fw_fwdable = '0; fw_wdata = '0;
    applyStimulus(1'b0, 5'd0, 5'd0, 2'd0, 3'd0, 64'd0);
    nextEdge();
    nextEdge();
    checkOutput("reset_out_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("reset_op1", {32'd0, out_op1}, 64'd0);
    checkOutput("reset_rs_data", out_rs_data, 64'd0);
    checkOutput("reset_stall", {32'd0, stall_cycles}, 64'd0);
    reset = 1'b0;
    nextEdge();

    // Plain register-file read, latency 1
    applyStimulus(1'b1, 5'd1, 5'd2, 2'd1, 3'd1, 64'd1);
    rf_rdata = {32'h22, 32'h11};
    #1;
    checkOutput("t1_in_ready", {63'd0, in_ready}, 64'd1);
    checkOutput("t1_rf_raddr", {54'd0, rf_raddr}, {54'd0, 5'd2, 5'd1});
    checkOutput("t1_valid_before_edge", {63'd0, out_valid}, 64'd0);
    nextEdge();
    checkOutput("t1_out_valid", {63'd0, out_valid}, 64'd1);
    checkOutput("t1_op1", {32'd0, out_op1}, 64'h11);
    checkOutput("t1_op2", {32'd0, out_op2}, 64'h22);
    checkOutput("t1_iid", out_iid, 64'd1);

    // Forwarding priority: youngest matching source wins
    applyStimulus(1'b1, 5'd5, 5'd0, 2'd1, 3'd0, 64'd2);
    setFw(0, 1'b1, 5'd5, 1'b0, 32'hA);
    setFw(2, 1'b1, 5'd5, 1'b1, 32'hC);
    #1;
    checkOutput("t2_young_blocks", {63'd0, hazard}, 64'd1);
    setFw(0, 1'b1, 5'd5, 1'b1, 32'hA);
    setFw(2, 1'b1, 5'd5, 1'b0, 32'hC);
    #1;
    checkOutput("t2_old_ignored", {63'd0, hazard}, 64'd0);
    setFw(2, 1'b1, 5'd5, 1'b1, 32'hC);
    #1;
    checkOutput("t2_in_ready", {63'd0, in_ready}, 64'd1);
    nextEdge();
    checkOutput("t2_op1", {32'd0, out_op1}, 64'hA);
    checkOutput("t2_rs_data0", {32'd0, out_rs_data[31:0]}, 64'hA);
    checkOutput("t2_iid", out_iid, 64'd2);

    // Hazard stall for three cycles, then forward once fwdable
    setFw(0, 1'b0, 5'd0, 1'b0, 32'h0);
    setFw(2, 1'b0, 5'd0, 1'b0, 32'h0);
    setFw(1, 1'b1, 5'd7, 1'b0, 32'h55);
    applyStimulus(1'b1, 5'd0, 5'd7, 2'd0, 3'd1, 64'd3);
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput("t3_hazard", {63'd0, hazard}, 64'd1);
      checkOutput("t3_in_ready", {63'd0, in_ready}, 64'd0);
      nextEdge();
    end
    checkOutput("t3_stall", {32'd0, stall_cycles}, 64'd3);
    checkOutput("t3_drained", {63'd0, out_valid}, 64'd0);
    setFw(1, 1'b1, 5'd7, 1'b1, 32'h77);
    #1;
    checkOutput("t3_released", {63'd0, in_ready}, 64'd1);
    nextEdge();
    checkOutput("t3_op2", {32'd0, out_op2}, 64'h77);
    checkOutput("t3_iid", out_iid, 64'd3);
    checkOutput("t3_stall_after", {32'd0, stall_cycles}, 64'd3);

    // x0 reads as zero and never matches a forwarding source
    setFw(1, 1'b0, 5'd0, 1'b0, 32'h0);
    setFw(0, 1'b1, 5'd0, 1'b0, 32'hBEEF);
    rf_rdata = {32'h22, 32'hDEAD};
    in_imm_u = 32'h1234_5000;
    applyStimulus(1'b1, 5'd0, 5'd0, 2'd1, 3'd5, 64'd4);
    #1;
    checkOutput("t4_no_hazard", {63'd0, hazard}, 64'd0);
    nextEdge();
    checkOutput("t4_op1_x0", {32'd0, out_op1}, 64'd0);
    checkOutput("t4_rs_data0", {32'd0, out_rs_data[31:0]}, 64'd0);
    checkOutput("t4_op2_immu", {32'd0, out_op2}, 64'h1234_5000);
    in_pc = 32'h8000_0004;
    in_imm_i = 32'h1; in_imm_s = 32'h2; in_imm_j = 32'h3; in_imm_z = 32'h4;
    applyStimulus(1'b1, 5'd0, 5'd0, 2'd2, 3'd6, 64'd5);
    nextEdge();
    checkOutput("t4_op1_pc", {32'd0, out_op1}, 64'h8000_0004);
    checkOutput("t4_op2_sel6", {32'd0, out_op2}, 64'd0);
    checkOutput("t4_pc", {32'd0, out_pc}, 64'h8000_0004);
    setFw(0, 1'b0, 5'd0, 1'b0, 32'h0);

    // Backpressure hold, then consume and accept on the same edge
    in_pc = 32'h100; in_imm_i = 32'h10;
    applyStimulus(1'b1, 5'd0, 5'd0, 2'd2, 3'd2, 64'd10);
    nextEdge();
    checkOutput("t5_first_iid", out_iid, 64'd10);
    out_ready = 1'b0;
    in_pc = 32'h200; in_imm_i = 32'h20;
    applyStimulus(1'b1, 5'd0, 5'd0, 2'd2, 3'd2, 64'd11);
    for (int i = 0; i < 4; i++) begin
      #1;
      checkOutput("t5_in_ready_held", {63'd0, in_ready}, 64'd0);
      nextEdge();
      checkOutput("t5_hold_valid", {63'd0, out_valid}, 64'd1);
      checkOutput("t5_hold_iid", out_iid, 64'd10);
      checkOutput("t5_hold_op1", {32'd0, out_op1}, 64'h100);
    end
    out_ready = 1'b1;
    #1;
    checkOutput("t5_in_ready_free", {63'd0, in_ready}, 64'd1);
    nextEdge();
    checkOutput("t5_swap_valid", {63'd0, out_valid}, 64'd1);
    checkOutput("t5_swap_iid", out_iid, 64'd11);
    checkOutput("t5_swap_op2", {32'd0, out_op2}, 64'h20);
    checkOutput("t5_stall_unchanged", {32'd0, stall_cycles}, 64'd3);

    // Flush kills the held slot and blocks the waiting input
    applyStimulus(1'b1, 5'd0, 5'd0, 2'd2, 3'd2, 64'd12);
    flush = 1'b1;
    #1;
    checkOutput("t6_flush_in_ready", {63'd0, in_ready}, 64'd0);
    nextEdge();
    checkOutput("t6_flush_valid", {63'd0, out_valid}, 64'd0);
    flush = 1'b0;

    // Asynchronous reset in the middle of a hold
    applyStimulus(1'b1, 5'd0, 5'd0, 2'd2, 3'd2, 64'd13);
    nextEdge();
    checkOutput("t7_loaded_iid", out_iid, 64'd13);
    out_ready = 1'b0;
    applyStimulus(1'b0, 5'd0, 5'd0, 2'd0, 3'd0, 64'd0);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("t7_reset_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("t7_reset_stall", {32'd0, stall_cycles}, 64'd0);
    checkOutput("t7_reset_iid", out_iid, 64'd0);
    nextEdge();
    reset = 1'b0;
    nextEdge();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
